// File: rtl/fft16_input_reorder.sv
// Ping-pong input reorder for the 16-point radix-4 FFT: captures a frame, then issues
// four groups {x[g], x[g+4], x[g+8], x[g+12]}. Define FFT_IN_SCALE_EN to pre-shift samples.
module fft16_input_reorder #(
    parameter int DW          = 16,
    parameter int SCALE_SHIFT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Ar,
    output logic [DW-1:0] Br,
    output logic [DW-1:0] Cr,
    output logic [DW-1:0] Dr,
    output logic [DW-1:0] Ai,
    output logic [DW-1:0] Bi,
    output logic [DW-1:0] Ci,
    output logic [DW-1:0] Di,
    output logic [1:0]    out_grp,
    output logic          out_sof,
    output logic          out_eof,
    output logic          frame_err
);

`ifdef FFT_IN_SCALE_EN
    localparam bit ScaleEn = 1'b1;
`else
    localparam bit ScaleEn = 1'b0;
`endif

    logic [DW-1:0] mem_r_q [2][16];
    logic [DW-1:0] mem_i_q [2][16];

    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic [3:0]    widx_q, widx_d;
    logic          rbank_q, rbank_d;
    logic [1:0]    rgrp_q, rgrp_d;
    logic          frame_err_q, frame_err_d;
    logic          out_valid_q, out_valid_d;
    logic [1:0]    out_grp_q, out_grp_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic [DW-1:0] out_r_q [4];
    logic [DW-1:0] out_r_d [4];
    logic [DW-1:0] out_i_q [4];
    logic [DW-1:0] out_i_d [4];

    logic                 acc;
    logic                 ld;
    logic signed [DW-1:0] sh_r, sh_i;
    logic [DW-1:0]        wr_r, wr_i;

    assign in_ready = !full_q[wbank_q];

    // Shift kept in signed-only expressions so >>> stays arithmetic
    always_comb begin
        sh_r = $signed(in_r) >>> SCALE_SHIFT;
        sh_i = $signed(in_i) >>> SCALE_SHIFT;
        wr_r = ScaleEn ? sh_r : in_r;
        wr_i = ScaleEn ? sh_i : in_i;
    end

    always_comb begin
        acc         = in_valid && in_ready;
        ld          = (!out_valid_q || out_ready) && full_q[rbank_q];
        full_d      = full_q;
        wbank_d     = wbank_q;
        widx_d      = widx_q;
        rbank_d     = rbank_q;
        rgrp_d      = rgrp_q;
        frame_err_d = frame_err_q;
        out_valid_d = out_valid_q;
        out_grp_d   = out_grp_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;

        if (acc) begin
            widx_d = widx_q + 4'd1;
            if (in_last != (widx_q == 4'd15)) begin
                frame_err_d = 1'b1;
            end
            if (widx_q == 4'd15) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
            end
        end

        // Writer only touches an empty bank, reader only a full one: never the same bank
        if (ld) begin
            out_valid_d = 1'b1;
            out_grp_d   = rgrp_q;
            out_sof_d   = (rgrp_q == 2'd0);
            out_eof_d   = (rgrp_q == 2'd3);
            for (int k = 0; k < 4; k++) begin
                out_r_d[k] = mem_r_q[rbank_q][{2'(k), rgrp_q}];
                out_i_d[k] = mem_i_q[rbank_q][{2'(k), rgrp_q}];
            end
            rgrp_d = rgrp_q + 2'd1;
            if (rgrp_q == 2'd3) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = !rbank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            mem_r_q[wbank_q][widx_q] <= wr_r;
            mem_i_q[wbank_q][widx_q] <= wr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= '0;
            wbank_q     <= 1'b0;
            widx_q      <= '0;
            rbank_q     <= 1'b0;
            rgrp_q      <= '0;
            frame_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_grp_q   <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_r_q     <= '{default: '0};
            out_i_q     <= '{default: '0};
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            widx_q      <= widx_d;
            rbank_q     <= rbank_d;
            rgrp_q      <= rgrp_d;
            frame_err_q <= frame_err_d;
            out_valid_q <= out_valid_d;
            out_grp_q   <= out_grp_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_grp   = out_grp_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign frame_err = frame_err_q;
    assign Ar        = out_r_q[0];
    assign Br        = out_r_q[1];
    assign Cr        = out_r_q[2];
    assign Dr        = out_r_q[3];
    assign Ai        = out_i_q[0];
    assign Bi        = out_i_q[1];
    assign Ci        = out_i_q[2];
    assign Di        = out_i_q[3];

endmodule

// File: tb/tb_fft16_input_reorder.sv
// Bench for fft16_input_reorder: frame-level reference model with an output scoreboard.
// Build with FFT_IN_SCALE_EN defined to exercise the capture shift.
module tb_fft16_input_reorder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_r = '0;
    logic [15:0] in_i = '0;
    logic        in_ready, out_valid, out_sof, out_eof, frame_err;
    logic [15:0] Ar, Br, Cr, Dr, Ai, Bi, Ci, Di;
    logic [1:0]  out_grp;

    fft16_input_reorder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .Ar(Ar), .Br(Br), .Cr(Cr), .Dr(Dr),
        .Ai(Ai), .Bi(Bi), .Ci(Ci), .Di(Di),
        .out_grp(out_grp), .out_sof(out_sof), .out_eof(out_eof),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ar, br, cr, dr, ai, bi, ci, di;
        logic [1:0]  grp;
        logic        sof, eof;
    } grp_t;

    grp_t        got_q[$];
    grp_t        exp_q[$];
    logic [15:0] m_r[16];
    logic [15:0] m_i[16];
    int          m_idx = 0;
    logic        m_err = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic grp_t cur_out();
        grp_t g;
        g.ar = Ar; g.br = Br; g.cr = Cr; g.dr = Dr;
        g.ai = Ai; g.bi = Bi; g.ci = Ci; g.di = Di;
        g.grp = out_grp; g.sof = out_sof; g.eof = out_eof;
        return g;
    endfunction

    // Capture value: floor(x / 2^2) when scaling, else x unchanged
    function automatic logic [15:0] scl(input logic [15:0] x);
`ifdef FFT_IN_SCALE_EN
        int v;
        v = int'($signed(x));
        v = (v < 0) ? -((-v + 3) / 4) : v / 4;
        return v[15:0];
`else
        return x;
`endif
    endfunction

    function automatic void model_accept(input logic [15:0] r, input logic [15:0] i,
                                         input logic last);
        grp_t g;
        if (last != (m_idx == 15)) m_err = 1'b1;
        m_r[m_idx] = scl(r);
        m_i[m_idx] = scl(i);
        if (m_idx == 15) begin
            for (int k = 0; k < 4; k++) begin
                g.ar = m_r[k]; g.br = m_r[k+4]; g.cr = m_r[k+8]; g.dr = m_r[k+12];
                g.ai = m_i[k]; g.bi = m_i[k+4]; g.ci = m_i[k+8]; g.di = m_i[k+12];
                g.grp = 2'(k); g.sof = (k == 0); g.eof = (k == 3);
                exp_q.push_back(g);
            end
        end
        m_idx = (m_idx + 1) % 16;
    endfunction

    function automatic void model_reset();
        m_idx = 0;
        m_err = 1'b0;
        exp_q.delete();
        got_q.delete();
    endfunction

    // A group counts as delivered when valid and ready are both seen before the edge
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) got_q.push_back(cur_out());
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [15:0] r, input logic [15:0] i, input logic last);
        int w = 0;
        in_valid = 1'b1; in_r = r; in_i = i; in_last = last;
        #1;
        while (!in_ready && w < 200) begin
            @(negedge clk); #1; w++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end else begin
            model_accept(r, i, last);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++; $display("FAIL rst_frame_err got %b want 0", frame_err);
        end
        n_cmp++;
        if ({out_grp, out_sof, out_eof} !== 4'b0) begin
            n_err++; $display("FAIL rst_flags got %b want 0", {out_grp, out_sof, out_eof});
        end
        n_cmp++;
        if (cur_out() !== grp_t'(0)) begin
            n_err++; $display("FAIL rst_data got %h want 0", cur_out());
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int w = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) send(16'(n * 256), 16'(-n), n == 15);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_latency out_valid got %b want 0", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (!(out_valid === 1'b1 && out_grp === 2'(k) &&
                  out_sof === (k == 0) && out_eof === (k == 3))) begin
                n_err++;
                $display("FAIL basic_seq%0d got v=%b g=%0d s=%b e=%b want v=1 g=%0d",
                         k, out_valid, out_grp, out_sof, out_eof, k);
            end
`ifndef FFT_IN_SCALE_EN
            if (k == 1) begin
                n_cmp++;
                if ({Ar, Br, Cr, Dr, Ai, Bi, Ci, Di} !==
                    {16'd256, 16'd1280, 16'd2304, 16'd3328,
                     16'hFFFF, 16'hFFFB, 16'hFFF7, 16'hFFF3}) begin
                    n_err++;
                    $display("FAIL basic_g1 got %h want 0100/0500/0900/0d00 ffff/fffb/fff7/fff3",
                             {Ar, Br, Cr, Dr, Ai, Bi, Ci, Di});
                end
            end
`endif
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_idle out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        while (got_q.size() < exp_q.size() && w < 100) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL basic_grp%0d got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int w = 0;
        out_ready = 1'b0;
        for (int n = 0; n < 32; n++) send(16'($urandom()), 16'($urandom()), (n % 16) == 15);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_full in_ready got %b want 0", in_ready);
        end
        n_cmp++;
        if (!(out_valid === 1'b1 && out_grp === 2'd0)) begin
            n_err++; $display("FAIL b2b_g0 got v=%b g=%0d want v=1 g=0", out_valid, out_grp);
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || cur_out() !== exp_q[0]) begin
            n_err++; $display("FAIL b2b_hold in_ready=%b out=%h want 0 %h",
                              in_ready, cur_out(), exp_q[0]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (in_ready !== (k == 2)) begin
                n_err++; $display("FAIL b2b_release%0d in_ready got %b want %b",
                                  k, in_ready, k == 2);
            end
        end
        @(negedge clk);
        for (int n = 0; n < 16; n++) send(16'($urandom()), 16'($urandom()), n == 15);
        @(negedge clk);
        while (got_q.size() < exp_q.size() && w < 100) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL b2b_grp%0d got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_ready();
        int   w = 0;
        grp_t prev = '0;
        logic stall = 1'b0;
        out_ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send(16'($urandom()), 16'($urandom()), n == 15);
        end
        while (got_q.size() < exp_q.size() && w < 200) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || cur_out() !== prev) begin
                    n_err++; $display("FAIL rnd_stable got v=%b %h want v=1 %h",
                                      out_valid, cur_out(), prev);
                end
            end
            stall = out_valid && !out_ready;
            prev  = cur_out();
            w++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL rnd_grp%0d got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_err();
        int w = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            send(16'($urandom()), 16'($urandom()), n == 14);
            n_cmp++;
            if (frame_err !== m_err) begin
                n_err++; $display("FAIL ferr_s%0d got %b want %b", n, frame_err, m_err);
            end
        end
        @(negedge clk);
        while (got_q.size() < exp_q.size() && w < 100) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL ferr_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL ferr_grp%0d got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_err++; $display("FAIL ferr_sticky got %b want 1", frame_err);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int w = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) send(16'($urandom()), 16'($urandom()), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({out_valid, frame_err, in_ready} !== 3'b001) begin
            n_err++; $display("FAIL rst9 v/err/rdy got %b want 001", {out_valid, frame_err, in_ready});
        end
        @(negedge clk);
        for (int n = 0; n < 16; n++) send(16'($urandom()), 16'($urandom()), n == 15);
        while (got_q.size() < 2 && w < 50) begin
            @(negedge clk); #3; w++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, frame_err, in_ready, out_grp} !== 5'b00100) begin
            n_err++; $display("FAIL rstmid v/err/rdy/grp got %b want 00100",
                              {out_valid, frame_err, in_ready, out_grp});
        end
        model_reset();
        @(negedge clk);
        for (int n = 0; n < 16; n++) send(16'($urandom()), 16'($urandom()), n == 15);
        w = 0;
        @(negedge clk);
        while (got_q.size() < exp_q.size() && w < 100) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL rstmid_grp%0d got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_scale();
        int          w = 0;
`ifdef FFT_IN_SCALE_EN
        logic [15:0] want_r = 16'hFFFE;
        logic [15:0] want_i = 16'h1000;
`else
        logic [15:0] want_r = 16'hFFFB;
        logic [15:0] want_i = 16'h4000;
`endif
        out_ready = 1'b1;
        send(16'hFFFB, 16'h4000, 1'b0);
        for (int n = 1; n < 16; n++) send(16'($urandom()), 16'($urandom()), n == 15);
        @(negedge clk);
        while (got_q.size() < exp_q.size() && w < 100) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (got_q.size() == 0 || got_q[0].ar !== want_r || got_q[0].ai !== want_i) begin
            n_err++;
            $display("FAIL scale_g0 got n=%0d ar/ai=%h want %h/%h", got_q.size(),
                     got_q.size() > 0 ? {got_q[0].ar, got_q[0].ai} : 32'h0, want_r, want_i);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL scale_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL scale_grp%0d got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_ready();
        test_frame_err();
        test_reset_mid();
        test_scale();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
